// File: rtl/sw_event_pkg.sv
// -----------------------------------------------------------------------------
// sw_event_pkg
// Shared types and constants for the switch event reader.
//   dbnc_state_t : per-channel debounce FSM states
//   EVT_PRESS    : event_code MSB value for a press event
//   EVT_RELEASE  : event_code MSB value for a release event
// -----------------------------------------------------------------------------
package sw_event_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } dbnc_state_t;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

endpackage

// File: rtl/sw_debounce_chan.sv
// -----------------------------------------------------------------------------
// sw_debounce_chan
// One switch channel: 2-FF synchroniser, debounce FSM and stability counter.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   sw_raw   : raw asynchronous switch pin
//   level    : debounced state, 1 = pressed
//   press    : one-cycle pulse when a press is accepted
//   rel      : one-cycle pulse when a release is accepted
// -----------------------------------------------------------------------------
module sw_debounce_chan
    import sw_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic              INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic              sync1_reg, sync2_reg;
    logic              sync_act;
    dbnc_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              level_reg, level_next;
    logic              press_reg, press_next;
    logic              rel_reg, rel_next;

    // Sync flops reset to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= INACTIVE;
            sync2_reg <= INACTIVE;
        end else begin
            sync1_reg <= sw_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalise polarity: 1 means "pressed" from here on.
    assign sync_act = sync2_reg ^ INACTIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            rel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            press_reg <= press_next;
            rel_reg   <= rel_next;
        end
    end

    // The counter is compared before it is incremented, so it tops out at
    // DEBOUNCE_CYCLES-1 and never wraps.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        press_next = 1'b0;
        rel_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sync_act) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_act) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = PRESSED;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_act) begin
                    state_next = REL_WAIT;
                    cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (sync_act) begin
                    state_next = PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    level_next = 1'b0;
                    rel_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign level = level_reg;
    assign press = press_reg;
    assign rel   = rel_reg;

endmodule

// File: rtl/sw_event_reader.sv
// -----------------------------------------------------------------------------
// sw_event_reader
// Debounces N_SW raw switches and presents press/release events one at a time
// on a valid/ready handshake.
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset (deasserted synchronously to clk)
//   SW          : raw switch pins
//   sw_level    : debounced state per switch, 1 = pressed
//   sw_press    : one-cycle press pulse per switch
//   sw_release  : one-cycle release pulse per switch
//   event_valid : an event is held on event_code
//   event_ready : consumer accepts the held event
//   event_code  : MSB 1 = press / 0 = release, LSBs = switch index
//   event_ovf   : sticky, an event was lost
// -----------------------------------------------------------------------------
module sw_event_reader
    import sw_event_pkg::*;
#(
    parameter int N_SW            = 4,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SW-1:0]       SW,
    output logic [N_SW-1:0]       sw_level,
    output logic [N_SW-1:0]       sw_press,
    output logic [N_SW-1:0]       sw_release,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [$clog2(N_SW):0] event_code,
    output logic                  event_ovf
);

    localparam int CODE_W = $clog2(N_SW) + 1;
    localparam int NP     = 2 * N_SW;

    // Pending vector layout: bit 2*i = press of ch i, bit 2*i+1 = release of
    // ch i, so an ascending scan gives the required priority order.
    logic [NP-1:0]     pulse;
    logic [NP-1:0]     pending_reg, pending_next;
    logic [NP-1:0]     avail, sel_mask, consumed;
    logic              found, load_en;
    logic [CODE_W-1:0] sel_code;
    logic              valid_reg, valid_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic              ovf_reg, ovf_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_SW; gi++) begin : g_chan
            sw_debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .sw_raw (SW[gi]),
                .level  (sw_level[gi]),
                .press  (sw_press[gi]),
                .rel    (sw_release[gi])
            );
            assign pulse[2*gi]   = sw_press[gi];
            assign pulse[2*gi+1] = sw_release[gi];
        end
    endgenerate

    // Fresh pulses are visible to the selector directly, so an event reaches
    // an empty output slot one edge after its pulse instead of two.
    assign avail = pending_reg | pulse;

    always_comb begin
        found    = 1'b0;
        sel_mask = '0;
        sel_code = '0;
        for (int k = 0; k < NP; k++) begin
            if (avail[k] && !found) begin
                found       = 1'b1;
                sel_mask[k] = 1'b1;
                sel_code    = CODE_W'(k / 2);
                sel_code[CODE_W-1] = (k % 2 == 0) ? EVT_PRESS : EVT_RELEASE;
            end
        end
    end

    assign load_en  = !valid_reg || event_ready;
    assign consumed = (load_en && found) ? sel_mask : '0;

    always_comb begin
        // A consumed bit that was already pending is cleared, but a pulse on
        // the same bit re-sets it (set wins). A consumed bit that was only a
        // fresh pulse is delivered straight away and never stored.
        pending_next = (pending_reg & ~consumed) | (pulse & ~(consumed & ~pending_reg));
        // Overflow only when a pulse hits a pending bit that is not leaving.
        ovf_next     = ovf_reg | (|(pulse & pending_reg & ~consumed));
        valid_next   = valid_reg;
        code_next    = code_reg;
        if (load_en) begin
            valid_next = found;
            if (found) begin
                code_next = sel_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
            valid_reg   <= 1'b0;
            code_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            valid_reg   <= valid_next;
            code_reg    <= code_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign event_valid = valid_reg;
    assign event_code  = code_reg;
    assign event_ovf   = ovf_reg;

endmodule
